// File: rtl/vec_replay_buffer_pkg.sv
// Shared types and helpers for the ping-pong vector replay buffer.
// Holds the per-bank lifecycle encoding and counter-width helpers.
package vec_replay_buffer_pkg;

  localparam int unsigned ElemWidth = 8;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_REPLAYING
  } bank_state_e;

  // Width for a counter over n values; never zero, so a single-value range still gets one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic holds_vector(input bank_state_e s);
    return (s == BANK_FULL) || (s == BANK_REPLAYING);
  endfunction

endpackage

// File: rtl/vec_replay_buffer_chunk_bank_ram.sv
// Simple dual-port chunk store: one synchronous write port, one registered read port.
// Address is {bank, chunk}; the read register gives the buffer its one-cycle latency.
module vec_replay_buffer_chunk_bank_ram #(
  parameter int AddrW = 2,
  parameter int DataW = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AddrW-1:0] wr_addr,
  input  logic [DataW-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AddrW-1:0] rd_addr,
  output logic [DataW-1:0] rd_data
);

  localparam int Depth = 1 << AddrW;

  logic [DataW-1:0] mem [Depth];

  // NOTE: storage has no reset; the bank full flags decide what is valid, so clearing it buys nothing.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Output register resets to zero and holds its value when no read is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/vec_replay_buffer.sv
// Ping-pong input-vector store feeding the matrix-vector stage: one bank is filled
// chunk by chunk while the other is replayed OutVecLength times on request.
module vec_replay_buffer
  import vec_replay_buffer_pkg::*;
#(
  parameter int InVecLength  = 6,
  parameter int OutVecLength = 2,
  parameter int WorkingRegs  = 3
) (
  input  logic                                         clk_in,
  input  logic                                         rst_in,
  input  logic                                         wr_valid,
  input  logic signed [WorkingRegs-1:0][ElemWidth-1:0] wr_data,
  output logic                                         wr_ready,
  output logic                                         vec_ready,
  input  logic                                         rd_req,
  output logic signed [WorkingRegs-1:0][ElemWidth-1:0] rd_data,
  output logic                                         rd_data_valid,
  output logic                                         err_underflow
);

  localparam int ChunksPerVec = InVecLength / WorkingRegs;
  localparam int ReadsPerVec  = ChunksPerVec * OutVecLength;
  localparam int ChunkW       = int'(cnt_width(ChunksPerVec));
  localparam int PassW        = int'(cnt_width(OutVecLength));
  localparam int AddrW        = ChunkW + 1;
  localparam int DataW        = WorkingRegs * ElemWidth;

  localparam logic [ChunkW-1:0] ChunkLast = ChunkW'(ChunksPerVec - 1);
  localparam logic [PassW-1:0]  PassLast  = PassW'(OutVecLength - 1);

  bank_state_e       bank_state    [2];
  bank_state_e       bank_state_nx [2];
  logic [1:0]        full;

  logic              wr_bank;
  logic [ChunkW-1:0] wr_chunk;
  logic              rd_bank;
  logic [ChunkW-1:0] rd_chunk;
  logic [PassW-1:0]  rd_pass;

  logic              wr_fire;
  logic              wr_last;
  logic              rd_fire;
  logic              rd_last;
  logic [1:0]        wr_hit;
  logic [1:0]        rd_hit;

  assign wr_fire = wr_valid && wr_ready;
  assign rd_fire = rd_req && vec_ready;
  assign wr_last = (wr_chunk == ChunkLast);
  assign rd_last = (rd_chunk == ChunkLast) && (rd_pass == PassLast);

  // Write and read can never hit the same bank in one cycle: one needs it empty, the other full.
  assign wr_hit = wr_fire ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign rd_hit = rd_fire ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;

  // Per-bank lifecycle: state register.
  // NOTE: every clocked block uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      bank_state[0] <= BANK_EMPTY;
      bank_state[1] <= BANK_EMPTY;
    end else begin
      bank_state <= bank_state_nx;
    end
  end

  // Per-bank lifecycle: next-state logic.
  // NOTE: defaulting to the current state first keeps this block free of inferred latches.
  always_comb begin
    bank_state_nx = bank_state;
    for (int b = 0; b < 2; b++) begin
      unique case (bank_state[b])
        BANK_EMPTY:
          if (wr_hit[b]) bank_state_nx[b] = wr_last ? BANK_FULL : BANK_FILLING;
        BANK_FILLING:
          if (wr_hit[b] && wr_last) bank_state_nx[b] = BANK_FULL;
        BANK_FULL:
          if (rd_hit[b]) bank_state_nx[b] = rd_last ? BANK_EMPTY : BANK_REPLAYING;
        BANK_REPLAYING:
          if (rd_hit[b] && rd_last) bank_state_nx[b] = BANK_EMPTY;
        default:
          bank_state_nx[b] = BANK_EMPTY;
      endcase
    end
  end

  // Per-bank lifecycle: outputs. Handshakes look only at registered state, so a
  // bank released this cycle is writable from the next one.
  always_comb begin
    full[0] = holds_vector(bank_state[0]);
    full[1] = holds_vector(bank_state[1]);
  end

  assign wr_ready  = !full[wr_bank];
  assign vec_ready = full[rd_bank];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_bank  <= 1'b0;
      wr_chunk <= '0;
    end else if (wr_fire) begin
      if (wr_last) begin
        wr_chunk <= '0;
        wr_bank  <= ~wr_bank;
      end else begin
        wr_chunk <= wr_chunk + ChunkW'(1);
      end
    end
  end

  // Read cursor walks chunks within a pass, then passes within the vector.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_bank  <= 1'b0;
      rd_chunk <= '0;
      rd_pass  <= '0;
    end else if (rd_fire) begin
      if (rd_chunk == ChunkLast) begin
        rd_chunk <= '0;
        if (rd_pass == PassLast) begin
          rd_pass <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_pass <= rd_pass + PassW'(1);
        end
      end else begin
        rd_chunk <= rd_chunk + ChunkW'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_data_valid <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      rd_data_valid <= rd_fire;
      if (rd_req && !vec_ready) begin
        err_underflow <= 1'b1;
      end
    end
  end

  vec_replay_buffer_chunk_bank_ram #(
    .AddrW (AddrW),
    .DataW (DataW)
  ) u_ram (
    .clk     (clk_in),
    .rst_n   (rst_in),
    .wr_en   (wr_fire),
    .wr_addr ({wr_bank, wr_chunk}),
    .wr_data (wr_data),
    .rd_en   (rd_fire),
    .rd_addr ({rd_bank, rd_chunk}),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_vec_replay_buffer.sv
// Self-checking bench for vec_replay_buffer: a queue-based model of stored vectors
// checked every cycle, plus directed vectors with literal expected chunks.
module tb_vec_replay_buffer;

  localparam int InVecLength  = 6;
  localparam int OutVecLength = 2;
  localparam int WorkingRegs  = 3;
  localparam int Cpv          = InVecLength / WorkingRegs;
  localparam int Rpv          = Cpv * OutVecLength;

  typedef logic [WorkingRegs-1:0][7:0] chunk_t;

  logic   clk_in   = 1'b0;
  logic   rst_in   = 1'b0;
  logic   wr_valid = 1'b0;
  logic   rd_req   = 1'b0;
  chunk_t wr_data  = '0;
  logic   wr_ready;
  logic   vec_ready;
  logic   rd_data_valid;
  logic   err_underflow;
  logic signed [WorkingRegs-1:0][7:0] rd_data;

  int n_checks = 0;
  int n_errors = 0;

  // Model: complete vectors as a flat chunk queue, the vector being written, and reads served.
  chunk_t vq[$];
  chunk_t part[$];
  int     rd_n      = 0;
  logic   exp_valid = 1'b0;
  logic   exp_err   = 1'b0;
  chunk_t exp_data  = '0;
  bit     model_on  = 1'b0;

  vec_replay_buffer #(
    .InVecLength  (InVecLength),
    .OutVecLength (OutVecLength),
    .WorkingRegs  (WorkingRegs)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .wr_valid      (wr_valid),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .vec_ready     (vec_ready),
    .rd_req        (rd_req),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .err_underflow (err_underflow)
  );

  always #5 clk_in = ~clk_in;

  function automatic chunk_t mk(input int a, input int b, input int c);
    chunk_t r;
    r[0] = 8'(a);
    r[1] = 8'(b);
    r[2] = 8'(c);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    vq.delete();
    part.delete();
    rd_n      = 0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    exp_data  = '0;
  endtask

  // One clock edge of the model, using the inputs as the DUT sampled them.
  task automatic model_step();
    bit can_wr;
    bit can_rd;
    can_wr    = (vq.size() / Cpv) < 2;
    can_rd    = vq.size() > 0;
    exp_valid = rd_req && can_rd;
    if (rd_req && !can_rd) exp_err = 1'b1;
    if (rd_req && can_rd) begin
      exp_data = vq[rd_n % Cpv];
      rd_n++;
      if (rd_n == Rpv) begin
        repeat (Cpv) void'(vq.pop_front());
        rd_n = 0;
      end
    end
    if (wr_valid && can_wr) begin
      part.push_back(wr_data);
      if (part.size() == Cpv) begin
        foreach (part[i]) vq.push_back(part[i]);
        part.delete();
      end
    end
  endtask

  always @(negedge clk_in) begin
    if (model_on) begin
      check("wr_ready",      wr_ready,      64'((vq.size() / Cpv) < 2));
      check("vec_ready",     vec_ready,     64'(vq.size() > 0));
      check("rd_data_valid", rd_data_valid, 64'(exp_valid));
      check("err_underflow", err_underflow, 64'(exp_err));
      check("rd_data",       rd_data,       64'(exp_data));
    end
  end

  task automatic tick();
    @(posedge clk_in);
    if (rst_in) model_step();
    @(negedge clk_in);
    #1;
  endtask

  task automatic wr(input chunk_t c);
    wr_valid = 1'b1;
    wr_data  = c;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic rd_expect(input string name, input chunk_t c);
    rd_req = 1'b1;
    tick();
    check({name, "_valid"}, rd_data_valid, 1);
    check({name, "_data"},  rd_data, c);
    check({name, "_model"}, exp_data, c);
  endtask

  chunk_t a0, a1, b0, b1;

  initial begin
    a0 = mk(1, 2, 3);
    a1 = mk(4, 5, 6);
    b0 = mk(7, 8, 9);
    b1 = mk(10, 11, 12);
    model_reset();
    repeat (3) @(negedge clk_in);
    #1;
    rst_in   = 1'b1;
    model_on = 1'b1;
    check("reset_wr_ready",  wr_ready, 1);
    check("reset_vec_ready", vec_ready, 0);
    check("reset_valid",     rd_data_valid, 0);
    check("reset_err",       err_underflow, 0);
    check("reset_rd_data",   rd_data, 0);
    tick();

    // Single vector, four back-to-back requests.
    wr(a0);
    check("vec_ready_partial", vec_ready, 0);
    wr(a1);
    check("vec_ready_filled", vec_ready, 1);
    for (int i = 0; i < Rpv; i++) rd_expect("replay", (i % 2) ? a1 : a0);
    rd_req = 1'b0;
    check("vec_ready_drained", vec_ready, 0);
    check("err_before_underflow", err_underflow, 0);

    // Underflow: request with nothing stored.
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("underflow_valid", rd_data_valid, 0);
    check("underflow_err",   err_underflow, 1);
    check("underflow_hold",  rd_data, a1);

    // Ping-pong: B is written during A's replay, then follows with no bubble.
    wr(a0);
    wr(a1);
    for (int i = 0; i < 2 * Rpv; i++) begin
      wr_valid = (i < 2);
      wr_data  = (i == 0) ? b0 : b1;
      rd_expect("pingpong", (i < Rpv) ? ((i % 2) ? a1 : a0) : ((i % 2) ? b1 : b0));
      if (i == Rpv - 1) check("pingpong_vec_ready_kept", vec_ready, 1);
    end
    wr_valid = 1'b0;
    rd_req   = 1'b0;
    check("pingpong_drained", vec_ready, 0);

    // Backpressure: both banks full, third vector ignored.
    wr(a0);
    wr(a1);
    check("wr_ready_one_full", wr_ready, 1);
    wr(b0);
    wr(b1);
    check("wr_ready_both_full", wr_ready, 0);
    wr(mk(20, 21, 22));
    wr(mk(23, 24, 25));
    check("wr_ready_still_blocked", wr_ready, 0);
    for (int i = 0; i < Rpv; i++) begin
      rd_expect("bp_a", (i % 2) ? a1 : a0);
      if (i == Rpv - 2) check("wr_ready_before_release", wr_ready, 0);
    end
    check("wr_ready_after_release", wr_ready, 1);
    for (int i = 0; i < Rpv; i++) rd_expect("bp_b", (i % 2) ? b1 : b0);
    rd_req = 1'b0;

    // New vector lands at chunk 0 (the ignored writes left nothing behind); reset mid-replay.
    wr(mk(30, 31, 32));
    wr(mk(40, 41, 42));
    rd_expect("d_read", mk(30, 31, 32));
    rd_expect("d_read", mk(40, 41, 42));
    rd_req = 1'b0;
    check("err_sticky", err_underflow, 1);
    #2;
    rst_in = 1'b0;
    model_reset();
    #1;
    check("midreset_wr_ready",  wr_ready, 1);
    check("midreset_vec_ready", vec_ready, 0);
    check("midreset_valid",     rd_data_valid, 0);
    check("midreset_err",       err_underflow, 0);
    @(negedge clk_in);
    #1;
    rst_in = 1'b1;
    tick();

    wr(mk(50, 51, 52));
    wr(mk(60, 61, 62));
    for (int i = 0; i < Rpv; i++) rd_expect("e_read", (i % 2) ? mk(60, 61, 62) : mk(50, 51, 52));
    rd_req = 1'b0;
    tick();
    check("final_vec_ready", vec_ready, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
